// File: rtl/spi_rom_arbiter.sv
// Two-requester round-robin arbiter in front of a mode-0 SPI EEPROM.
// Each grant issues one READ (0x03) command and streams bytes through a valid/ready handshake.
module spi_rom_arbiter #(
    parameter int SCK_DIV = 1,
    parameter int ADDR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [15:0]           req_len,
    output logic [1:0]            grant,
    output logic [7:0]            rd_data,
    output logic [1:0]            rd_valid,
    input  logic [1:0]            rd_ready,
    output logic [1:0]            done,
    output logic                  busy,
    output logic                  spi_sck,
    output logic                  spi_cs_n,
    output logic                  spi_copi,
    input  logic                  spi_cipo
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_HOLD,
        ST_CS_HIGH
    } state_t;

    localparam int         SHIFT_W    = 8 + ADDR_W;
    localparam logic [8:0] HALF_LAST  = 9'(SCK_DIV - 1);
    localparam logic [8:0] DESEL_LAST = 9'(2 * SCK_DIV - 1);
    localparam logic [4:0] ADDR_LAST  = 5'(ADDR_W - 1);

    logic [ADDR_W-1:0] addr_arr [2];
    logic [7:0]        len_arr  [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign len_arr[gi]  = req_len[gi*8 +: 8];
        end
    endgenerate

    state_t             state_reg,  state_next;
    logic [8:0]         div_reg,    div_next;
    logic               sck_reg,    sck_next;
    logic               cs_n_reg,   cs_n_next;
    logic               copi_reg,   copi_next;
    logic [4:0]         bit_reg,    bit_next;
    logic [SHIFT_W-1:0] shift_reg,  shift_next;
    logic [7:0]         rx_reg,     rx_next;
    logic [7:0]         data_reg,   data_next;
    logic [1:0]         valid_reg,  valid_next;
    logic [1:0]         done_reg,   done_next;
    logic [1:0]         grant_reg,  grant_next;
    logic               owner_reg,  owner_next;
    logic               last_reg,   last_next;
    logic [8:0]         remain_reg, remain_next;
    logic               abort_reg,  abort_next;

    logic owner_valid;
    logic half_end;
    logic pick;
    logic abort_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            div_reg    <= '0;
            sck_reg    <= 1'b0;
            cs_n_reg   <= 1'b1;
            copi_reg   <= 1'b0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            rx_reg     <= '0;
            data_reg   <= '0;
            valid_reg  <= '0;
            done_reg   <= '0;
            grant_reg  <= '0;
            owner_reg  <= 1'b0;
            last_reg   <= 1'b1;
            remain_reg <= '0;
            abort_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            div_reg    <= div_next;
            sck_reg    <= sck_next;
            cs_n_reg   <= cs_n_next;
            copi_reg   <= copi_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            rx_reg     <= rx_next;
            data_reg   <= data_next;
            valid_reg  <= valid_next;
            done_reg   <= done_next;
            grant_reg  <= grant_next;
            owner_reg  <= owner_next;
            last_reg   <= last_next;
            remain_reg <= remain_next;
            abort_reg  <= abort_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        div_next    = div_reg;
        sck_next    = sck_reg;
        cs_n_next   = cs_n_reg;
        copi_next   = copi_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        rx_next     = rx_reg;
        data_next   = data_reg;
        valid_next  = valid_reg;
        done_next   = 2'b00;
        grant_next  = grant_reg;
        owner_next  = owner_reg;
        last_next   = last_reg;
        remain_next = remain_reg;
        abort_next  = abort_reg;

        owner_valid = req_valid[owner_reg];
        half_end    = (div_reg == HALF_LAST);
        pick        = (req_valid == 2'b11) ? ~last_reg : req_valid[1];
        abort_now   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                sck_next  = 1'b0;
                cs_n_next = 1'b1;
                copi_next = 1'b0;
                div_next  = '0;
                if (req_valid != 2'b00) begin
                    owner_next  = pick;
                    grant_next  = pick ? 2'b10 : 2'b01;
                    shift_next  = {8'h03, addr_arr[pick]};
                    remain_next = (len_arr[pick] == 8'd0) ? 9'd256 : {1'b0, len_arr[pick]};
                    abort_next  = 1'b0;
                    cs_n_next   = 1'b0;
                    state_next  = ST_CS_SETUP;
                end
            end

            ST_CS_SETUP: begin
                if (half_end) begin
                    div_next   = '0;
                    bit_next   = 5'd7;
                    copi_next  = shift_reg[SHIFT_W-1];
                    shift_next = {shift_reg[SHIFT_W-2:0], 1'b0};
                    state_next = ST_CMD;
                end else begin
                    div_next = div_reg + 9'd1;
                end
            end

            // Each bit is a low half then a high half; an abort is honoured only at period end.
            ST_CMD, ST_ADDR, ST_DATA: begin
                abort_now  = abort_reg | ~owner_valid;
                abort_next = abort_now;
                if (!half_end) begin
                    div_next = div_reg + 9'd1;
                end else begin
                    div_next = '0;
                    if (!sck_reg) begin
                        sck_next = 1'b1;
                        if (state_reg == ST_DATA)
                            rx_next = {rx_reg[6:0], spi_cipo};
                    end else begin
                        sck_next = 1'b0;
                        if (abort_now) begin
                            cs_n_next  = 1'b1;
                            copi_next  = 1'b0;
                            state_next = ST_CS_HIGH;
                        end else if (bit_reg != 5'd0) begin
                            bit_next = bit_reg - 5'd1;
                            if (state_reg != ST_DATA) begin
                                copi_next  = shift_reg[SHIFT_W-1];
                                shift_next = {shift_reg[SHIFT_W-2:0], 1'b0};
                            end
                        end else if (state_reg == ST_CMD) begin
                            bit_next   = ADDR_LAST;
                            copi_next  = shift_reg[SHIFT_W-1];
                            shift_next = {shift_reg[SHIFT_W-2:0], 1'b0};
                            state_next = ST_ADDR;
                        end else if (state_reg == ST_ADDR) begin
                            bit_next   = 5'd7;
                            copi_next  = 1'b0;
                            state_next = ST_DATA;
                        end else begin
                            data_next  = rx_reg;
                            valid_next = grant_reg;
                            state_next = ST_HOLD;
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (!owner_valid) begin
                    valid_next = 2'b00;
                    cs_n_next  = 1'b1;
                    div_next   = '0;
                    state_next = ST_CS_HIGH;
                end else if ((valid_reg & rd_ready) != 2'b00) begin
                    valid_next  = 2'b00;
                    remain_next = remain_reg - 9'd1;
                    div_next    = '0;
                    if (remain_reg == 9'd1) begin
                        done_next  = grant_reg;
                        cs_n_next  = 1'b1;
                        state_next = ST_CS_HIGH;
                    end else begin
                        bit_next   = 5'd7;
                        state_next = ST_DATA;
                    end
                end
            end

            ST_CS_HIGH: begin
                sck_next  = 1'b0;
                cs_n_next = 1'b1;
                copi_next = 1'b0;
                if (div_reg == DESEL_LAST) begin
                    div_next   = '0;
                    grant_next = 2'b00;
                    last_next  = owner_reg;
                    state_next = ST_IDLE;
                end else begin
                    div_next = div_reg + 9'd1;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign grant    = grant_reg;
    assign rd_data  = data_reg;
    assign rd_valid = valid_reg;
    assign done     = done_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign spi_sck  = sck_reg;
    assign spi_cs_n = cs_n_reg;
    assign spi_copi = copi_reg;

endmodule

// File: tb/tb_spi_rom_arbiter.sv
// Bench for spi_rom_arbiter: behavioural SPI EEPROM, byte scoreboard and directed/random reads.
module tb_spi_rom_arbiter;

    localparam int SCK_DIV  = 1;
    localparam int ADDR_W   = 8;
    localparam int HDR_BITS = 8 + ADDR_W;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          req_valid;
    logic [2*ADDR_W-1:0] req_addr;
    logic [15:0]         req_len;
    logic [1:0]          grant;
    logic [7:0]          rd_data;
    logic [1:0]          rd_valid;
    logic [1:0]          rd_ready;
    logic [1:0]          done;
    logic                busy;
    logic                spi_sck;
    logic                spi_cs_n;
    logic                spi_copi;
    logic                spi_cipo = 1'b0;

    always #5 clk = ~clk;

    spi_rom_arbiter #(.SCK_DIV(SCK_DIV), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .grant(grant), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .busy(busy),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_copi(spi_copi), .spi_cipo(spi_cipo)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] mem [256];
    int ready_mode = 0;

    // EEPROM model: captures the header on rising edges, shifts data out on falling edges
    int rise_cnt = 0;
    int rise_total = 0;
    logic [HDR_BITS-1:0] hdr_shift = '0;
    logic [HDR_BITS-1:0] hdr_last  = '0;

    always @(posedge spi_sck or negedge spi_cs_n) begin
        if (!spi_sck) begin
            rise_cnt  = 0;
            hdr_shift = '0;
        end else if (!spi_cs_n) begin
            rise_total++;
            if (rise_cnt < HDR_BITS) begin
                hdr_shift = {hdr_shift[HDR_BITS-2:0], spi_copi};
                if (rise_cnt == HDR_BITS - 1) hdr_last = hdr_shift;
            end
            rise_cnt++;
        end
    end

    always @(negedge spi_sck) begin
        int idx;
        logic [7:0] a;
        logic [7:0] b;
        if (!spi_cs_n && rise_cnt >= HDR_BITS) begin
            idx = rise_cnt - HDR_BITS;
            a = hdr_last[7:0] + 8'(idx / 8);
            b = mem[a];
            spi_cipo = b[7 - (idx % 8)];
        end else begin
            spi_cipo = 1'b0;
        end
    end

    initial begin
        rd_ready = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: rd_ready = 2'b11;
                1: rd_ready = 2'($urandom);
                default: rd_ready = 2'b00;
            endcase
        end
    end

    logic [7:0] got0 [$];
    logic [7:0] got1 [$];
    int done_total [2] = '{0, 0};
    int rdv1_total = 0;
    int proto_err = 0;
    logic prev_copi = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid[0] && rd_ready[0]) got0.push_back(rd_data);
            if (rd_valid[1] && rd_ready[1]) got1.push_back(rd_data);
            if (done[0]) done_total[0]++;
            if (done[1]) done_total[1]++;
            if (rd_valid[1]) rdv1_total++;
            if ((rd_valid & ~grant) != 2'b00 || grant == 2'b11) proto_err++;
            if (spi_cs_n && (spi_sck || spi_copi)) proto_err++;
            if (spi_copi != prev_copi && spi_sck) proto_err++;
        end
        prev_copi = spi_copi;
    end

    int snap_bytes, snap_done, snap_rise;
    int last_served = 1;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int n);
        return (n == 1) ? got1.size() : got0.size();
    endfunction

    function automatic logic [7:0] qget(input int n, input int i);
        return (n == 1) ? got1[i] : got0[i];
    endfunction

    function automatic int arb_pick(input logic [1:0] rv, input int last);
        if (rv == 2'b11) return 1 - last;
        return rv[1] ? 1 : 0;
    endfunction

    task automatic snapshot(input int n);
        snap_bytes = qsize(n);
        snap_done  = done_total[n];
        snap_rise  = rise_total;
    endtask

    task automatic start_read(input int n, input logic [7:0] addr, input logic [7:0] len);
        req_addr[n*ADDR_W +: ADDR_W] = addr;
        req_len[n*8 +: 8] = len;
        req_valid[n] = 1'b1;
    endtask

    task automatic finish_read(input int n, input logic [7:0] addr, input logic [7:0] len, input string tag);
        int cyc;
        int exp_len;
        int errs;
        logic [7:0] want;
        exp_len = (len == 8'd0) ? 256 : int'(len);
        errs = 0;
        cyc = 0;
        while (!done[n] && cyc < 20000) begin
            tick();
            cyc++;
        end
        check({tag, " done before timeout"}, 32'(cyc < 20000), 1);
        req_valid[n] = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            tick();
            cyc++;
        end
        check({tag, " busy low"}, 32'(busy), 0);
        check({tag, " grant idle"}, 32'(grant), 0);
        check({tag, " byte count"}, 32'(qsize(n) - snap_bytes), 32'(exp_len));
        for (int i = 0; i < exp_len; i++) begin
            want = mem[8'(int'(addr) + i)];
            if (snap_bytes + i >= qsize(n) || qget(n, snap_bytes + i) !== want) errs++;
        end
        check({tag, " data mismatches"}, 32'(errs), 0);
        check({tag, " done pulses"}, 32'(done_total[n] - snap_done), 1);
        check({tag, " sck rising edges"}, 32'(rise_total - snap_rise), 32'(HDR_BITS + 8 * exp_len));
        check({tag, " copi header"}, 32'(hdr_last), 32'({8'h03, addr}));
        last_served = n;
    endtask

    task automatic read_one(input int n, input logic [7:0] addr, input logic [7:0] len, input string tag);
        snapshot(n);
        start_read(n, addr, len);
        finish_read(n, addr, len, tag);
    endtask

    initial begin
        int cyc;
        int exp_n;
        int rdv_base;
        int size_after;
        logic [7:0] a_tab [2];
        logic [7:0] l_tab [2];
        logic [7:0] ra;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hA5;
        mem[8'h11] = 8'h3C;
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_addr = '0;
        req_len = '0;
        repeat (3) tick();

        check("reset cs_n", 32'(spi_cs_n), 1);
        check("reset sck", 32'(spi_sck), 0);
        check("reset copi", 32'(spi_copi), 0);
        check("reset grant", 32'(grant), 0);
        check("reset rd_valid", 32'(rd_valid), 0);
        check("reset done", 32'(done), 0);
        check("reset busy", 32'(busy), 0);
        check("reset rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        tick();

        // Both requesting: round-robin order from a reset pointer of 1
        ready_mode = 0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 2; k++) begin
                a_tab[k] = 8'($urandom);
                l_tab[k] = 8'(1 + $urandom % 3);
                start_read(k, a_tab[k], l_tab[k]);
            end
            for (int k = 0; k < 2; k++) begin
                exp_n = arb_pick(req_valid, last_served);
                cyc = 0;
                while (grant == 2'b00 && cyc < 100) begin
                    tick();
                    cyc++;
                end
                check("arb grant", 32'(grant), (exp_n == 1) ? 32'h2 : 32'h1);
                snapshot(exp_n);
                finish_read(exp_n, a_tab[exp_n], l_tab[exp_n], "arb read");
            end
        end

        read_one(0, 8'h10, 8'd2, "single read");
        check("single byte0", 32'(got0[got0.size() - 2]), 32'hA5);
        check("single byte1", 32'(got0[got0.size() - 1]), 32'h3C);

        // Backpressure on the first byte
        ready_mode = 2;
        tick();
        tick();
        snapshot(0);
        start_read(0, 8'h10, 8'd2);
        cyc = 0;
        while (!rd_valid[0] && cyc < 200) begin
            tick();
            cyc++;
        end
        check("bp first byte timeout", 32'(cyc < 200), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp hold sck/cs/data/valid", 32'({spi_sck, spi_cs_n, rd_data, rd_valid[0]}),
                  32'({1'b0, 1'b0, 8'hA5, 1'b1}));
        end
        ready_mode = 0;
        finish_read(0, 8'h10, 8'd2, "bp read");

        ready_mode = 1;
        for (int t = 0; t < 6; t++) begin
            read_one(int'($urandom % 2), 8'($urandom), 8'(1 + $urandom % 6), "random read");
        end

        // Abort requester 1 in the middle of byte 3 of 5
        ready_mode = 0;
        tick();
        ra = 8'($urandom);
        snapshot(1);
        start_read(1, ra, 8'd5);
        cyc = 0;
        while (got1.size() - snap_bytes < 2 && cyc < 500) begin
            tick();
            cyc++;
        end
        check("abort two bytes timeout", 32'(cyc < 500), 1);
        repeat (5) tick();
        rdv_base = rdv1_total;
        req_valid[1] = 1'b0;
        cyc = 0;
        while (!spi_cs_n && cyc < 50) begin
            tick();
            cyc++;
        end
        check("abort cs_n within one sck period", 32'(cyc <= 2 * SCK_DIV), 1);
        cyc = 0;
        while (busy && cyc < 50) begin
            tick();
            cyc++;
        end
        check("abort idle", 32'(busy), 0);
        check("abort byte count", 32'(got1.size() - snap_bytes), 2);
        check("abort no rd_valid", 32'(rdv1_total - rdv_base), 0);
        check("abort no done", 32'(done_total[1] - snap_done), 0);
        last_served = 1;

        ready_mode = 1;
        read_one(0, 8'h00, 8'd0, "len0 read");

        // Asynchronous reset during DATA
        ready_mode = 0;
        snapshot(0);
        start_read(0, 8'($urandom), 8'd4);
        cyc = 0;
        while (got0.size() - snap_bytes < 1 && cyc < 500) begin
            tick();
            cyc++;
        end
        check("reset-test first byte timeout", 32'(cyc < 500), 1);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset cs_n", 32'(spi_cs_n), 1);
        check("midreset sck", 32'(spi_sck), 0);
        check("midreset grant/valid/busy", 32'({grant, rd_valid, busy}), 0);
        req_valid = 2'b00;
        repeat (3) tick();
        rst_n = 1'b1;
        last_served = 1;
        size_after = got0.size();
        repeat (5) tick();
        check("no byte after reset", 32'(got0.size()), 32'(size_after));
        read_one(0, 8'($urandom), 8'd3, "post-reset read");

        check("protocol violations", 32'(proto_err), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
